// File: rtl/font_pkg.sv
// rtl/font_pkg.sv - shared widths and one-hot/index helpers for the font ROM arbiter
package font_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 4;

    // Helpers work at the widest supported requester count; callers slice down.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    function automatic logic [MAX_REQ-1:0] to_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] to_index(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin : pick
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (eligible[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - round-robin arbiter sharing one synchronous font ROM among N_REQ requesters
module font_rom_arbiter
    import font_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_dout,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]   ptr;
    logic [N_REQ-1:0]   eligible;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [MAX_REQ-1:0] pick_oh;

    // A requester that was granted last cycle is still dropping its req; skip it.
    assign eligible = req & ~grant;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    always_comb begin
        sel_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
        pick_oh  = to_onehot(MAX_IDX_W'(pick_idx));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant     <= '0;
            rsp_valid <= '0;
            rom_addr  <= '0;
            ptr       <= '0;
        end else begin
            rsp_valid <= grant;
            if (pick_valid) begin
                grant    <= pick_oh[N_REQ-1:0];
                rom_addr <= sel_addr;
                if (int'(pick_idx) == N_REQ - 1) ptr <= '0;
                else                             ptr <= pick_idx + 1'b1;
            end else begin
                grant <= '0;
            end
        end
    end

    assign rsp_data = rom_dout;
    assign busy     = (|grant) | (|rsp_valid);

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    grant;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_dout;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0]  m_grant, m_rsp;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_ptr;

    font_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .grant     (grant),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [7:0] t;
        t = {2'b00, a} * 8'd5 + 8'd3;
        return t[DW-1:0];
    endfunction

    always @(posedge clk) rom_dout <= rom_fn(rom_addr);

    task automatic set_lane(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic model_reset();
        m_grant = '0;
        m_rsp   = '0;
        m_addr  = '0;
        m_ptr   = 0;
    endtask

    // Advance one clock; the model applies the arbitration rules to the inputs seen at that edge.
    task automatic step();
        logic [N-1:0]  ng;
        logic [AW-1:0] na;
        logic [DW-1:0] nd;
        int            np;
        int            k;
        bit            found;
        ng = '0;
        na = m_addr;
        np = m_ptr;
        nd = rom_fn(m_addr);
        found = 0;
        for (int off = 0; off < N; off++) begin
            k = (m_ptr + off) % N;
            if (!found && req[k] && !m_grant[k]) begin
                found = 1;
                ng    = '0;
                ng[k] = 1'b1;
                na    = req_addr[k*AW +: AW];
                np    = (k + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        m_rsp   = m_grant;
        m_data  = nd;
        m_grant = ng;
        m_addr  = na;
        m_ptr   = np;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req     = '0;
        reset_n = 1'b0;
        #3;
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        do_reset();
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset_idle_grant: got %b expected 0000", grant); end
    endtask

    task automatic test_single();
        do_reset();
        set_lane(2, 6'd13);
        req = 4'b0100;
        step();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", grant); end
        n_checks++; if (rom_addr !== 6'd13) begin n_fail++; $display("FAIL single_rom_addr: got %0d expected 13", rom_addr); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        req = '0;
        step();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_off: got %b expected 0000", grant); end
        n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0100", rsp_valid); end
        n_checks++; if (rsp_data !== rom_fn(6'd13)) begin n_fail++; $display("FAIL single_rsp_data: got %h expected %h", rsp_data, rom_fn(6'd13)); end
        n_checks++; if (dut.ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d expected 3", dut.ptr); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_fairness();
        logic [AW-1:0] lane [N];
        logic [N-1:0]  exp_g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            lane[i] = AW'($urandom_range(0, 63));
            set_lane(i, lane[i]);
        end
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_g = (c < 4) ? N'(1 << c) : '0;
            n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL fair_grant c%0d: got %b expected %b", c, grant, exp_g); end
            if (c < 4) begin
                n_checks++; if (rom_addr !== lane[c]) begin n_fail++; $display("FAIL fair_rom_addr c%0d: got %0d expected %0d", c, rom_addr, lane[c]); end
            end
            req = req & ~grant;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_lane(2, 6'd7);
        req = 4'b0100;
        step();
        req = '0;
        step();
        set_lane(0, 6'd21);
        set_lane(3, 6'd50);
        req = 4'b1001;
        step();
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b expected 1000", grant); end
        n_checks++; if (rom_addr !== 6'd50) begin n_fail++; $display("FAIL wrap_addr3: got %0d expected 50", rom_addr); end
        req = req & ~grant;
        step();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: got %b expected 0001", grant); end
        n_checks++; if (rom_addr !== 6'd21) begin n_fail++; $display("FAIL wrap_addr0: got %0d expected 21", rom_addr); end
        req = '0;
        n_checks++; if (dut.ptr !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr: got %0d expected 1", dut.ptr); end
        step();
    endtask

    task automatic test_lone();
        logic [N-1:0] exp_g, exp_r;
        do_reset();
        set_lane(1, 6'd33);
        req = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            step();
            exp_g = (c % 2 == 0) ? 4'b0010 : 4'b0000;
            exp_r = (c % 2 == 1) ? 4'b0010 : 4'b0000;
            n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL lone_grant c%0d: got %b expected %b", c, grant, exp_g); end
            n_checks++; if (rsp_valid !== exp_r) begin n_fail++; $display("FAIL lone_rsp c%0d: got %b expected %b", c, rsp_valid, exp_r); end
        end
        req = '0;
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_lane(1, 6'd44);
        req = 4'b0010;
        step();
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL midrst_pre_grant: got %b expected 0010", grant); end
        req     = '0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL midrst_grant: got %b expected 0000", grant); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL midrst_rsp: got %b expected 0000", rsp_valid); end
        n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL midrst_addr: got %0d expected 0", rom_addr); end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL midrst_no_rsp: got %b expected 0000", rsp_valid); end
        req = 4'b1111;
        step();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b expected 0001", grant); end
        req = '0;
        step();
    endtask

    task automatic test_x_lane();
        do_reset();
        set_lane(0, 6'd42);
        req_addr[3*AW +: AW] = 'x;
        req = 4'b0001;
        step();
        n_checks++; if (rom_addr !== 6'd42) begin n_fail++; $display("FAIL xlane_addr: got %0d expected 42", rom_addr); end
        n_checks++; if ($isunknown(rom_addr)) begin n_fail++; $display("FAIL xlane_known: got %b expected no X", rom_addr); end
        req = '0;
        step();
    endtask

    task automatic test_random();
        logic exp_busy;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) set_lane(i, AW'($urandom_range(0, 63)));
            req = (req & ~grant) | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
            step();
            exp_busy = (|m_grant) | (|m_rsp);
            n_checks++; if (grant !== m_grant) begin n_fail++; $display("FAIL rand_grant c%0d: got %b expected %b", c, grant, m_grant); end
            n_checks++; if (rom_addr !== m_addr) begin n_fail++; $display("FAIL rand_addr c%0d: got %0d expected %0d", c, rom_addr, m_addr); end
            n_checks++; if (rsp_valid !== m_rsp) begin n_fail++; $display("FAIL rand_rsp c%0d: got %b expected %b", c, rsp_valid, m_rsp); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, exp_busy); end
            if (|m_rsp) begin
                n_checks++; if (rsp_data !== m_data) begin n_fail++; $display("FAIL rand_data c%0d: got %h expected %h", c, rsp_data, m_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_lone();
        test_mid_reset();
        test_x_lane();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
